// File: rtl/histo_pkg.sv
// Shared types for the histogram read path: gray bin address, bin count, and the
// tag that travels alongside each read so the response can be routed back.
package histo_pkg;

    localparam int GRAY_W  = 8;
    localparam int HIST_W  = 20;
    localparam int MAX_REQ = 8;

    typedef logic [GRAY_W-1:0] gray_t;
    typedef logic [HIST_W-1:0] hist_t;

    // req is sized for the largest requester count so every client shares one tag layout
    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] req;
        gray_t              gray;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from pointer+1,
// pointer moves to the winner on the next edge. No grant and no pointer move when en_i is low.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int SW = PW + 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          found;

    // Reset pointer to the last requester so requester 0 wins the first search
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, ptr_q} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[PW-1:0];
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_d      = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/histo_read_arbiter.sv
// Shares the registered histogram/cumulative read port among N_REQ requesters, one read per cycle.
// Response RD_LAT+2 cycles after grant; iHold blocks new grants while in-flight reads drain.
module histo_read_arbiter
    import histo_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int RD_LAT = 3,
    parameter int AW     = GRAY_W,
    parameter int DW     = HIST_W
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [N_REQ-1:0]    iReq,
    input  logic [N_REQ*AW-1:0] iAddr,
    output logic [N_REQ-1:0]    oGnt,
    input  logic                iHold,
    output logic [AW-1:0]       oRdAddr,
    input  logic [DW-1:0]       iRdHisto,
    input  logic [DW-1:0]       iRdCum,
    output logic [N_REQ-1:0]    oRvalid,
    output logic [AW-1:0]       oRGray,
    output logic [DW-1:0]       oRHisto,
    output logic [DW-1:0]       oRCum,
    output logic                oIdle
);

    logic [N_REQ-1:0] gnt;
    logic [AW-1:0]    sel_addr;
    logic             any_gnt;
    logic             busy;

    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    rd_tag_t          tag_q [RD_LAT+1];
    rd_tag_t          tag_d;
    logic [DW-1:0]    histo_s_q, cum_s_q;

    logic [N_REQ-1:0] rvalid_q, rvalid_d;
    logic [AW-1:0]    rgray_q, rgray_d;
    logic [DW-1:0]    rhisto_q, rhisto_d;
    logic [DW-1:0]    rcum_q, rcum_d;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk_i (iClk),
        .rst_i (iRst),
        .en_i  (~iHold & ~iRst),
        .req_i (iReq),
        .gnt_o (gnt)
    );

    assign oGnt    = gnt;
    assign any_gnt = |gnt;

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_addr = iAddr[k*AW +: AW];
            end
        end
    end

    always_comb begin
        rd_addr_d = any_gnt ? sel_addr : rd_addr_q;
        tag_d     = '0;
        if (any_gnt) begin
            tag_d.valid = 1'b1;
            tag_d.req   = MAX_REQ'(gnt);
            tag_d.gray  = GRAY_W'(sel_addr);
        end
    end

    // Last tag stage lines up with the data sampled from the datapath on the same edge
    always_comb begin
        rvalid_d = '0;
        rgray_d  = rgray_q;
        rhisto_d = rhisto_q;
        rcum_d   = rcum_q;
        if (tag_q[RD_LAT].valid) begin
            rvalid_d = tag_q[RD_LAT].req[N_REQ-1:0];
            rgray_d  = AW'(tag_q[RD_LAT].gray);
            rhisto_d = histo_s_q;
            rcum_d   = cum_s_q;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rd_addr_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
            histo_s_q <= '0;
            cum_s_q   <= '0;
            rvalid_q  <= '0;
            rgray_q   <= '0;
            rhisto_q  <= '0;
            rcum_q    <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            tag_q[0]  <= tag_d;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            histo_s_q <= iRdHisto;
            cum_s_q   <= iRdCum;
            rvalid_q  <= rvalid_d;
            rgray_q   <= rgray_d;
            rhisto_q  <= rhisto_d;
            rcum_q    <= rcum_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    assign oIdle   = ~busy & ~any_gnt;
    assign oRdAddr = rd_addr_q;
    assign oRvalid = rvalid_q;
    assign oRGray  = rgray_q;
    assign oRHisto = rhisto_q;
    assign oRCum   = rcum_q;

endmodule

// File: tb/tb_histo_read_arbiter.sv
// Directed bench for histo_read_arbiter with a small RAM model behind the read port.
module tb_histo_read_arbiter;

    logic        iClk  = 1'b0;
    logic        iRst  = 1'b1;
    logic        iHold = 1'b0;
    logic [2:0]  iReq  = '0;
    logic [23:0] iAddr = '0;
    logic [2:0]  oGnt;
    logic [7:0]  oRdAddr;
    logic [19:0] iRdHisto;
    logic [19:0] iRdCum;
    logic [2:0]  oRvalid;
    logic [7:0]  oRGray;
    logic [19:0] oRHisto;
    logic [19:0] oRCum;
    logic        oIdle;

    logic [7:0]  dp1 = '0;
    logic [7:0]  dp2 = '0;

    int n_err = 0;
    int n_chk = 0;

    logic [2:0]  exp_g;
    logic [7:0]  exp_a;
    logic [2:0]  g3 [3];
    logic [7:0]  a3 [3];

    always #5 iClk = ~iClk;

    histo_read_arbiter dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iReq     (iReq),
        .iAddr    (iAddr),
        .oGnt     (oGnt),
        .iHold    (iHold),
        .oRdAddr  (oRdAddr),
        .iRdHisto (iRdHisto),
        .iRdCum   (iRdCum),
        .oRvalid  (oRvalid),
        .oRGray   (oRGray),
        .oRHisto  (oRHisto),
        .oRCum    (oRCum),
        .oIdle    (oIdle)
    );

    function automatic logic [19:0] bin_h(input logic [7:0] a);
        if (a == 8'd37) return 20'd1234;
        return 20'(a) * 20'd13 + 20'd7;
    endfunction

    function automatic logic [19:0] bin_c(input logic [7:0] a);
        if (a == 8'd37) return 20'd50000;
        return 20'(a) * 20'd100 + 20'd3;
    endfunction

    // Datapath model: two register stages after oRdAddr, data presented for the third edge
    always @(posedge iClk) begin
        dp1 <= oRdAddr;
        dp2 <= dp1;
    end
    assign iRdHisto = bin_h(dp2);
    assign iRdCum   = bin_c(dp2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge iClk);
    endtask

    initial begin
        // reset state, with requests asserted during reset
        repeat (2) step();
        iReq = 3'b111;
        #1;
        chk("rst_gnt", 32'(oGnt), 32'd0);
        chk("rst_rdaddr", 32'(oRdAddr), 32'd0);
        chk("rst_rvalid", 32'(oRvalid), 32'd0);
        chk("rst_rgray", 32'(oRGray), 32'd0);
        chk("rst_rhisto", 32'(oRHisto), 32'd0);
        chk("rst_rcum", 32'(oRCum), 32'd0);

        // single read from requester 0, bin 37
        step(); iRst = 1'b0; iReq = 3'b001; iAddr[7:0] = 8'd37; #1;
        chk("t1_gnt", 32'(oGnt), 32'b001);
        chk("t1_idle_c0", 32'(oIdle), 32'd0);
        step(); iReq = 3'b000; #1;
        chk("t1_rdaddr", 32'(oRdAddr), 32'd37);
        chk("t1_gnt_off", 32'(oGnt), 32'd0);
        repeat (3) step(); #1;
        chk("t1_rvalid_c4", 32'(oRvalid), 32'd0);
        chk("t1_idle_c4", 32'(oIdle), 32'd0);
        step(); #1;
        chk("t1_rvalid_c5", 32'(oRvalid), 32'b001);
        chk("t1_rgray", 32'(oRGray), 32'd37);
        chk("t1_rhisto", 32'(oRHisto), 32'd1234);
        chk("t1_rcum", 32'(oRCum), 32'd50000);
        chk("t1_idle_c5", 32'(oIdle), 32'd1);
        step(); #1;
        chk("t1_rvalid_c6", 32'(oRvalid), 32'd0);
        chk("t1_rhisto_hold", 32'(oRHisto), 32'd1234);

        // reset two cycles after a grant discards the read
        step(); iReq = 3'b010; iAddr[15:8] = 8'd50; #1;
        chk("t5_gnt", 32'(oGnt), 32'b010);
        step(); iReq = 3'b000; #1;
        step(); iRst = 1'b1; iReq = 3'b100; #1;
        chk("t5_gnt_in_rst", 32'(oGnt), 32'd0);
        step(); iRst = 1'b0; iReq = 3'b000; #1;
        chk("t5_rdaddr", 32'(oRdAddr), 32'd0);
        chk("t5_idle", 32'(oIdle), 32'd1);
        chk("t5_rgray", 32'(oRGray), 32'd0);
        chk("t5_rhisto", 32'(oRHisto), 32'd0);
        chk("t5_rcum", 32'(oRCum), 32'd0);
        repeat (2) step(); #1;
        chk("t5_no_rvalid", 32'(oRvalid), 32'd0);

        // all three requesting for 9 cycles: rotation from requester 0, no bubbles
        iAddr = {8'd30, 8'd20, 8'd10};
        for (int i = 0; i < 15; i++) begin
            step();
            iReq = (i < 9) ? 3'b111 : 3'b000;
            #1;
            if (i < 9) begin
                exp_g = 3'b001 << (i % 3);
                chk("t2_gnt", 32'(oGnt), 32'(exp_g));
            end
            if (i >= 5 && i < 14) begin
                exp_g = 3'b001 << ((i - 5) % 3);
                exp_a = 8'(((i - 5) % 3 + 1) * 10);
                chk("t2_rvalid", 32'(oRvalid), 32'(exp_g));
                chk("t2_rgray", 32'(oRGray), 32'(exp_a));
                chk("t2_rhisto", 32'(oRHisto), 32'(bin_h(exp_a)));
            end
            if (i == 14) chk("t2_rvalid_end", 32'(oRvalid), 32'd0);
        end

        // requests 101 from the reset pointer: requester 1 is never granted
        step(); iRst = 1'b1;
        step(); iRst = 1'b0;
        iAddr = {8'd2, 8'd99, 8'd1};
        g3[0] = 3'b001; g3[1] = 3'b100; g3[2] = 3'b001;
        a3[0] = 8'd1;   a3[1] = 8'd2;   a3[2] = 8'd1;
        for (int i = 0; i < 9; i++) begin
            step();
            iReq = (i < 3) ? 3'b101 : 3'b000;
            #1;
            if (i < 3) chk("t3_gnt", 32'(oGnt), 32'(g3[i]));
            if (i >= 5 && i < 8) begin
                chk("t3_rvalid", 32'(oRvalid), 32'(g3[i-5]));
                chk("t3_rgray", 32'(oRGray), 32'(a3[i-5]));
            end
            if (i == 8) chk("t3_rvalid_end", 32'(oRvalid), 32'd0);
        end

        // two reads in flight, then hold with all requesting; resume at pointer+1
        for (int i = 0; i < 15; i++) begin
            step();
            iHold = (i >= 2 && i < 8);
            iReq  = (i < 2) ? 3'b110 : ((i < 9) ? 3'b111 : 3'b000);
            #1;
            if (i == 0) chk("t4_gnt0", 32'(oGnt), 32'b010);
            if (i == 1) chk("t4_gnt1", 32'(oGnt), 32'b100);
            if (i >= 2 && i < 8) chk("t4_hold_gnt", 32'(oGnt), 32'd0);
            if (i == 4) chk("t4_idle_c4", 32'(oIdle), 32'd0);
            if (i == 5) begin
                chk("t4_rvalid_a", 32'(oRvalid), 32'b010);
                chk("t4_rgray_a", 32'(oRGray), 32'd99);
                chk("t4_idle_c5", 32'(oIdle), 32'd0);
            end
            if (i == 6) begin
                chk("t4_rvalid_b", 32'(oRvalid), 32'b100);
                chk("t4_rgray_b", 32'(oRGray), 32'd2);
                chk("t4_idle_c6", 32'(oIdle), 32'd1);
            end
            if (i == 7) chk("t4_idle_c7", 32'(oIdle), 32'd1);
            if (i == 8) chk("t4_resume_gnt", 32'(oGnt), 32'b001);
            if (i == 13) chk("t4_resume_rvalid", 32'(oRvalid), 32'b001);
        end

        // address boundaries from requester 2, back to back
        for (int i = 0; i < 8; i++) begin
            step();
            iReq = (i < 2) ? 3'b100 : 3'b000;
            iAddr[23:16] = (i == 0) ? 8'd0 : 8'd255;
            #1;
            if (i < 2) chk("t6_gnt", 32'(oGnt), 32'b100);
            if (i == 5) begin
                chk("t6_rvalid0", 32'(oRvalid), 32'b100);
                chk("t6_rgray0", 32'(oRGray), 32'd0);
                chk("t6_rhisto0", 32'(oRHisto), 32'd7);
                chk("t6_rcum0", 32'(oRCum), 32'd3);
            end
            if (i == 6) begin
                chk("t6_rvalid255", 32'(oRvalid), 32'b100);
                chk("t6_rgray255", 32'(oRGray), 32'd255);
                chk("t6_rhisto255", 32'(oRHisto), 32'd3322);
                chk("t6_rcum255", 32'(oRCum), 32'd25503);
            end
            if (i == 7) begin
                chk("t6_rvalid_end", 32'(oRvalid), 32'd0);
                chk("t6_rgray_hold", 32'(oRGray), 32'd255);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/histo_read_arbiter.md
Name: histo_read_arbiter

Overview:
- Shares the single registered read address port of the histogram / cumulative-histogram bank pair among N_REQ requesters (VGA overlay, equalisation LUT loader, UART dump).
- Round-robin arbitration, one read issued per cycle, fully pipelined.
- Returns each response tagged to its requester after a fixed latency.
- iHold lets the frame controller freeze new issues around bank swaps while in-flight reads drain.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- RD_LAT, 3, cycles from oRdAddr to valid iRdHisto/iRdCum at the datapath (address reg + RAM q reg + output reg)
- AW, 8, gray address width
- DW, 20, histogram count width

Ports:
- iClk  in  1  system clock
- iRst  in  1  synchronous, active-high reset
- iReq  in  N_REQ  per-requester read request, level; held until granted
- iAddr  in  N_REQ*AW  per-requester gray address; slice k belongs to requester k
- oGnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted request
- iHold  in  1  when high, no grants are issued
- oRdAddr  out  AW  registered address to the datapath read port
- iRdHisto  in  DW  histogram read data from the datapath
- iRdCum  in  DW  cumulative histogram read data from the datapath
- oRvalid  out  N_REQ  one-hot response strobe, registered
- oRGray  out  AW  address the current response belongs to
- oRHisto  out  DW  histogram count
- oRCum  out  DW  cumulative count
- oIdle  out  1  high when no read is in flight and no grant is issued this cycle

Behaviour:
- Reset (iRst sampled high at a clock edge):
  - oRdAddr=0, oRvalid=0, oRGray=0, oRHisto=0, oRCum=0.
  - Tag pipeline cleared; round-robin pointer = N_REQ-1, so requester 0 has highest priority first.
  - oGnt=0 while iRst is high.
  - Reset mid-operation discards every in-flight read: no oRvalid is ever produced for it.
- Arbitration, cycle t:
  - If iHold=0 and any iReq bit is set, grant the first set bit searching upward from pointer+1, wrapping modulo N_REQ.
  - oGnt bit k is high in cycle t. Pointer becomes k at the t+1 edge.
  - No requests, or iHold=1: oGnt=0 and the pointer is unchanged.
- A requester treats a cycle with oGnt[k]=1 as consumed. To issue another read it either keeps iReq high with a new address or drops iReq.
- Issue: at the t+1 edge, oRdAddr <= iAddr slice k. oRdAddr holds its last value when nothing is granted.
- Tag pipeline: a depth RD_LAT+1 shift register carries {valid, one-hot requester, gray}, advancing every cycle.
- Response:
  - iRdHisto/iRdCum are sampled at edge t+1+RD_LAT.
  - At edge t+2+RD_LAT: oRvalid[k]=1 for exactly one cycle, with oRGray, oRHisto, oRCum. Total latency from grant is RD_LAT+2 (default 5).
  - Data outputs hold their value when oRvalid=0.
- Throughput: one grant per cycle with no bubbles. Back-to-back grants produce back-to-back responses in grant order.
- Simultaneous events:
  - iHold rising in the same cycle as a request: no grant that cycle.
  - In-flight reads always complete regardless of iHold.
- oIdle = no valid bit in the tag pipeline AND oGnt=0. The frame controller swaps banks only when iHold=1 and oIdle=1.
- Single requester: granted every cycle it requests; no fairness penalty.
- Address wrap: a gray value of 255 is passed through unchanged. There is no arithmetic on addresses.

Decomposition:
- Shared package histo_pkg holds:
  - GRAY_W=8, HIST_W=20
  - typedef gray_t and hist_t
  - struct rd_tag_t {valid, req one-hot, gray}
- One sub-module, rr_arbiter: parameterised N, combinational one-hot grant from request vector and pointer, plus pointer update. Reused by the later DMA/UART dump block.
- Tag pipeline and output registers stay in the top.

Test Plan:
- Reset then single read: iReq=001, iAddr0=8'd37.
  - Required: oGnt=001 at cycle 0; oRdAddr=37 at cycle 1; oRvalid=001 at cycle 5.
  - oRGray=37; oRHisto/oRCum match the model's bin-37 values (e.g. 20'd1234 / 20'd50000).
- All three requesting continuously, iHold=0, for 9 cycles.
  - Required: grants 001,010,100 repeating, three times each.
  - 9 consecutive oRvalid pulses in the same order, no gaps.
- Requests 101 with pointer at reset.
  - Required: grants 001 then 100 then 001 (requester 1 never granted); responses 5 cycles after each grant.
- Two reads in flight, then iHold=1 with iReq=111.
  - Required: no oGnt while held; both in-flight responses still delivered.
  - oIdle rises 1 cycle after the last oRvalid-producing tag leaves the pipeline.
  - Release iHold: the grant resumes at pointer+1.
- iRst pulsed 2 cycles after a grant.
  - Required: no oRvalid appears at cycle 5; all outputs 0.
  - Next request after reset is granted to requester 0 first.
- Address boundaries: iAddr=0 and 255 back-to-back from requester 2.
  - Required: oRGray=0 then 255 on consecutive cycles, with the correct bin data for each.
